scan_ctrl: RTL
==============

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces every register to its reset value.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a scan in progress.
REQ-006 data_in  input  8  word to scan; captured on start acceptance.
REQ-007 busy  output  1  high while LOAD or SHIFT is active.
REQ-008 done  output  1  one-cycle pulse when a scan completes.
REQ-009 match_count  output  4  adjacent-equal-bit pair count of the last completed scan.
REQ-010 det_state  output  3  current detector state encoding, for debug.

Function
REQ-011 The controller FSM SHALL have four states:
- IDLE=00: start=1 captures data_in into the shift register, clears the count and detector, then goes to LOAD.
- LOAD=01: goes to SHIFT one cycle later.
- SHIFT=10: shifts out exactly 8 bits, MSB first, one per cycle.
- REPORT=11: asserts done for one cycle, then returns to IDLE.
REQ-012 In SHIFT, the controller SHALL present the current MSB to the detector as w, enable the detector, shift left by one, and count bits with a 3-bit index; it SHALL leave SHIFT on the edge that consumes bit 0.
REQ-013 The detector SHALL be a 5-state binary-encoded Moore FSM with states INIT=000, ZERO=001, ZERO2=010, ONE=011, ONE2=100.
REQ-014 Detector transitions when enabled:
- w=0: from INIT, ONE or ONE2 to ZERO; from ZERO or ZERO2 to ZERO2.
- w=1: from INIT, ZERO or ZERO2 to ONE; from ONE or ONE2 to ONE2.
- Unused encodings 101-111 go to INIT.
- When not enabled, the detector holds its state.
REQ-015 The detector SHALL assert z=1 only in ZERO2 and ONE2.
REQ-016 The detector SHALL have a synchronous clear input that forces INIT; clear has priority over enable.
REQ-017 match_count SHALL increment on the same edge the detector enters ZERO2 or ONE2. The final value SHALL equal the number of i in 0..6 with data_in[i]==data_in[i+1]; its range is 0..7 and it cannot overflow.
REQ-018 match_count SHALL hold its value from REPORT until the next accepted start.
REQ-019 Latency SHALL be fixed: with start accepted at edge 0, busy is high for cycles 1..9 and done is high in cycle 10 exactly.
REQ-020 A start asserted in LOAD, SHIFT or REPORT SHALL be ignored and SHALL NOT be queued.
REQ-021 abort=1 in LOAD or SHIFT SHALL return the FSM to IDLE on the next edge, clear match_count to 0 and clear the detector, with no done pulse.
REQ-022 abort=1 in IDLE or REPORT SHALL have no effect.
REQ-023 If start and abort are both high in IDLE, start SHALL win.
REQ-024 Unused controller encodings cannot occur; the FSM default branch SHALL go to IDLE.

Reset
REQ-025 On reset, outputs and internal state SHALL take these values:
- Controller to IDLE, detector to INIT.
- Shift register 8'h00, bit index 0.
- match_count 0, busy 0, done 0, det_state 000.
REQ-026 Reset asserted mid-scan SHALL abandon the scan immediately with no done pulse; after release, the block SHALL wait in IDLE for a fresh start.

Structure
REQ-027 The controller state encodings, detector state encodings and the word width constant (8) SHALL live in a shared package, scan_pkg.
REQ-028 The detector SHALL be a separate sub-module, seq_detect, with ports clk, reset, clear, en, w, z and state[2:0]; scan_ctrl SHALL instantiate it once.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Reset, then 3 idle cycles -> busy=0, done=0, match_count=0, det_state=000.
- start with data_in=8'hFF -> done high exactly in cycle 10, match_count=7; det_state ends at 100.
- data_in=8'hAA -> match_count=0; 8'hF0 -> 6; 8'h00 -> 7, det_state ends at 010.
- start pulsed again during SHIFT of 8'hAA -> ignored; one done only; match_count=0.
- abort at the 4th SHIFT cycle of 8'hFF -> IDLE next cycle, match_count=0, no done; a following start of 8'hCC gives match_count=4.
- reset asserted mid-SHIFT -> all outputs zero immediately, no done; a later scan of 8'h0F gives match_count=6.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared encodings and helpers for the scan controller and its adjacent-bit detector.
package scan_pkg;

  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_SHIFT  = 2'b10,
    ST_REPORT = 2'b11
  } ctrl_state_t;

  typedef enum logic [2:0] {
    DET_INIT  = 3'b000,
    DET_ZERO  = 3'b001,
    DET_ZERO2 = 3'b010,
    DET_ONE   = 3'b011,
    DET_ONE2  = 3'b100
  } det_state_t;

  // Detector transition for one enabled bit; shared so the controller can see the entry edge.
  function automatic det_state_t det_next(input det_state_t s, input logic w);
    det_state_t n;
    case (s)
      DET_INIT: begin
        if (w) n = DET_ONE;
        else   n = DET_ZERO;
      end
      DET_ZERO, DET_ZERO2: begin
        if (w) n = DET_ONE;
        else   n = DET_ZERO2;
      end
      DET_ONE, DET_ONE2: begin
        if (w) n = DET_ONE2;
        else   n = DET_ZERO;
      end
      default: n = DET_INIT;
    endcase
    return n;
  endfunction

  function automatic logic det_is_pair(input det_state_t s);
    return (s == DET_ZERO2) || (s == DET_ONE2);
  endfunction

endpackage

// File: rtl/seq_detect.sv
// Moore detector: z is high once the last two enabled bits were equal.
module seq_detect
  import scan_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       w,
  output logic       z,
  output logic [2:0] state
);

  det_state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= DET_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)   state_d = DET_INIT;
    else if (en) state_d = det_next(state_q, w);
  end

  always_comb begin
    z     = det_is_pair(state_q);
    state = state_q;
  end

endmodule

// File: rtl/scan_ctrl.sv
// Scan controller: loads a word, shifts it MSB first through seq_detect and
// reports how many adjacent bit pairs were equal.
module scan_ctrl
  import scan_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count,
  output logic [2:0]        det_state
);

  ctrl_state_t       state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic load, cancel, shift_en, det_clear, det_w;
  logic z_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = abort ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: begin
        if (abort)                                  state_d = ST_IDLE;
        else if (idx_q == IDX_W'(WORD_W - 1))       state_d = ST_REPORT;
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load      = (state_q == ST_IDLE) && start;
    cancel    = ((state_q == ST_LOAD) || (state_q == ST_SHIFT)) && abort;
    shift_en  = (state_q == ST_SHIFT) && !abort;
    det_clear = load || cancel;
    det_w     = sreg_q[WORD_W-1];
    busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    done      = (state_q == ST_REPORT);
  end

  // The count bumps on the very edge the detector moves into a pair state.
  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = data_in;
      idx_d  = '0;
      cnt_d  = '0;
    end else if (cancel) begin
      idx_d  = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
      idx_d  = idx_q + IDX_W'(1);
      if (det_is_pair(det_next(det_state_t'(det_state), det_w)))
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  seq_detect u_det (
    .clk   (clk),
    .reset (reset),
    .clear (det_clear),
    .en    (shift_en),
    .w     (det_w),
    .z     (z_unused),
    .state (det_state)
  );

  assign match_count = cnt_q;

endmodule
